// File: rtl/clock_pkg.sv
// Shared encodings and field limits for the digital clock time-keeping core.
package clock_pkg;

  localparam int unsigned FIELD_W  = 6;
  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  typedef enum logic [1:0] {
    MODE_RUN         = 2'd0,
    MODE_SET_HOURS   = 2'd1,
    MODE_SET_MINUTES = 2'd2
  } mode_e;

endpackage

// File: rtl/time_counter_if.sv
// Button inputs and time/mode outputs of the time-keeping core.
interface time_counter_if;

  logic                          set_i;
  logic                          inc_i;
  logic [clock_pkg::FIELD_W-1:0] seconds_o;
  logic [clock_pkg::FIELD_W-1:0] minutes_o;
  logic [clock_pkg::FIELD_W-1:0] hours_o;
  logic [1:0]                    mode_o;
  logic                          sec_tick_o;

  modport master (
    output set_i, inc_i,
    input  seconds_o, minutes_o, hours_o, mode_o, sec_tick_o
  );

  modport slave (
    input  set_i, inc_i,
    output seconds_o, minutes_o, hours_o, mode_o, sec_tick_o
  );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear (priority) and enable; flags the wrapping step.
module wrap_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] value_o,
  output logic         wrap_o
);

  logic [W-1:0] r_value;
  logic         w_at_max;

  assign w_at_max = (r_value == W'(MAX));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_value <= '0;
    end else if (clr_i) begin
      r_value <= '0;
    end else if (en_i) begin
      r_value <= w_at_max ? '0 : r_value + W'(1);
    end
  end

  assign value_o = r_value;
  assign wrap_o  = en_i & w_at_max;

endmodule

// File: rtl/time_counter.sv
// Digital clock core: 1 Hz prescaler, HH:MM:SS carry chain and a three-state set-mode FSM.
module time_counter
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  time_counter_if.slave  tc_if
);

  localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  mode_e r_mode;
  logic  r_set_prev;
  logic  r_inc_prev;
  logic  r_sec_tick;

  logic               w_set_edge;
  logic               w_inc_edge;
  logic               w_inc_only;
  logic               w_run;
  logic               w_tick;
  logic               w_leave_set;
  logic               w_sec_wrap;
  logic               w_min_wrap;
  logic               w_hour_wrap;
  logic               w_min_en;
  logic               w_hour_en;
  logic [PRESC_W-1:0] w_presc_val;
  logic [FIELD_W-1:0] w_sec;
  logic [FIELD_W-1:0] w_min;
  logic [FIELD_W-1:0] w_hour;
  logic               w_unused_ok;

  assign w_set_edge  = tc_if.set_i & ~r_set_prev;
  assign w_inc_edge  = tc_if.inc_i & ~r_inc_prev;
  // A simultaneous set edge swallows the increment.
  assign w_inc_only  = w_inc_edge & ~w_set_edge;
  assign w_run       = (r_mode == MODE_RUN);
  assign w_leave_set = (r_mode == MODE_SET_MINUTES) & w_set_edge;

  // Carries only propagate in RUN; set-mode increments never ripple.
  assign w_min_en  = (w_run & w_sec_wrap) | ((r_mode == MODE_SET_MINUTES) & w_inc_only);
  assign w_hour_en = (w_run & w_min_wrap) | ((r_mode == MODE_SET_HOURS) & w_inc_only);

  assign w_unused_ok = ^{w_presc_val, w_hour_wrap};

  wrap_counter #(.MAX(TICKS_PER_SEC - 1), .W(PRESC_W)) u_presc (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_run),
    .clr_i   (~w_run),
    .value_o (w_presc_val),
    .wrap_o  (w_tick)
  );

  wrap_counter #(.MAX(SEC_MAX), .W(FIELD_W)) u_sec (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_tick),
    .clr_i   (w_leave_set),
    .value_o (w_sec),
    .wrap_o  (w_sec_wrap)
  );

  wrap_counter #(.MAX(MIN_MAX), .W(FIELD_W)) u_min (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_min_en),
    .clr_i   (1'b0),
    .value_o (w_min),
    .wrap_o  (w_min_wrap)
  );

  wrap_counter #(.MAX(HOUR_MAX), .W(FIELD_W)) u_hour (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_hour_en),
    .clr_i   (1'b0),
    .value_o (w_hour),
    .wrap_o  (w_hour_wrap)
  );

  // Edge-detect history resets high so a button held through reset yields no edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mode     <= MODE_RUN;
      r_set_prev <= 1'b1;
      r_inc_prev <= 1'b1;
      r_sec_tick <= 1'b0;
    end else begin
      r_set_prev <= tc_if.set_i;
      r_inc_prev <= tc_if.inc_i;
      r_sec_tick <= w_tick;
      if (w_set_edge) begin
        unique case (r_mode)
          MODE_RUN:         r_mode <= MODE_SET_HOURS;
          MODE_SET_HOURS:   r_mode <= MODE_SET_MINUTES;
          MODE_SET_MINUTES: r_mode <= MODE_RUN;
          default:          r_mode <= MODE_RUN;
        endcase
      end
    end
  end

  assign tc_if.seconds_o  = w_sec;
  assign tc_if.minutes_o  = w_min;
  assign tc_if.hours_o    = w_hour;
  assign tc_if.mode_o     = r_mode;
  assign tc_if.sec_tick_o = r_sec_tick;

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter: stimulus queues expected states, a monitor checks them.
module tb_time_counter;

  localparam int unsigned TPS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  time_counter_if u_if ();

  time_counter #(.TICKS_PER_SEC(TPS)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .tc_if   (u_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    h;
    int    m;
    int    s;
    int    mode;
    bit    tick;
    int    cyc;
  } exp_t;

  exp_t sb[$];
  bit   chk_req  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  // Monitor: compares on every sec_tick pulse and on every explicit check request.
  always @(negedge clk) begin
    exp_t e;
    if (chk_req || (rst_n && u_if.sec_tick_o === 1'b1)) begin
      chk_req = 1'b0;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tick: cycle %0d got sec_tick_o=%b, required no pulse",
                 cyc, u_if.sec_tick_o);
      end else begin
        e = sb.pop_front();
        if (u_if.hours_o !== 6'(e.h) || u_if.minutes_o !== 6'(e.m) ||
            u_if.seconds_o !== 6'(e.s) || u_if.mode_o !== 2'(e.mode) ||
            u_if.sec_tick_o !== e.tick || (e.cyc >= 0 && cyc != e.cyc)) begin
          failures++;
          $display("FAIL %s: got %0d:%0d:%0d mode=%0d tick=%b cyc=%0d, required %0d:%0d:%0d mode=%0d tick=%b cyc=%0d",
                   e.name, u_if.hours_o, u_if.minutes_o, u_if.seconds_o, u_if.mode_o,
                   u_if.sec_tick_o, cyc, e.h, e.m, e.s, e.mode, e.tick, e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input int h, input int m, input int s,
                      input int mode, input bit tick, input int c);
    exp_t e;
    e.name = name; e.h = h; e.m = m; e.s = s; e.mode = mode; e.tick = tick; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check_now(input string name, input int h, input int m, input int s,
                           input int mode);
    push(name, h, m, s, mode, 1'b0, -1);
    chk_req = 1'b1;
  endtask

  task automatic pulse_set();
    u_if.set_i = 1'b1;
    step(1);
    u_if.set_i = 1'b0;
    step(1);
  endtask

  task automatic pulse_inc(input int n);
    repeat (n) begin
      u_if.inc_i = 1'b1;
      step(1);
      u_if.inc_i = 1'b0;
      step(1);
    end
  endtask

  int t0, te, tx, ty, tr;

  initial begin
    u_if.set_i = 1'b0;
    u_if.inc_i = 1'b0;
    rst_n      = 1'b0;

    step(2);
    check_now("reset_state", 0, 0, 0, 0);
    step(1);

    // Free run from reset: ticks 4 and 8 cycles after release.
    rst_n = 1'b1;
    t0 = cyc;
    push("run_tick1", 0, 0, 1, 0, 1'b1, t0 + 4);
    push("run_tick2", 0, 0, 2, 0, 1'b1, t0 + 8);
    step(8);

    // Preload 23:59, then run up to 23:59:59 and roll over to 00:00:00.
    pulse_set();
    pulse_inc(23);
    pulse_set();
    pulse_inc(59);
    check_now("preload_23_59", 23, 59, 2, 2);
    te = cyc + 1;
    pulse_set();
    check_now("exit_set_clears_sec", 23, 59, 0, 0);
    for (int k = 1; k <= 60; k++) begin
      push($sformatf("rollover_tick%0d", k), (k < 60) ? 23 : 0, (k < 60) ? 59 : 0,
           k % 60, 0, 1'b1, te + 4 * k);
    end
    step(239);

    // Hours set with wrap through 23 -> 0.
    pulse_set();
    pulse_inc(25);
    check_now("hours_wrap", 1, 0, 0, 1);

    // Simultaneous set and inc edges: mode advances, hours untouched.
    u_if.set_i = 1'b1;
    u_if.inc_i = 1'b1;
    step(1);
    u_if.set_i = 1'b0;
    u_if.inc_i = 1'b0;
    step(1);
    check_now("set_inc_same_cycle", 1, 0, 0, 2);

    // Minutes set with wrap through 59 -> 0, no carry into hours.
    pulse_inc(61);
    check_now("minutes_wrap", 1, 1, 0, 2);
    tx = cyc + 1;
    pulse_set();
    check_now("exit_to_run", 1, 1, 0, 0);
    push("first_tick_after_set", 1, 1, 1, 0, 1'b1, tx + 4);
    push("second_tick_after_set", 1, 1, 2, 0, 1'b1, tx + 8);
    step(7);

    // Build 12:34:56 and park in SET_MINUTES.
    pulse_set();
    pulse_inc(11);
    pulse_set();
    pulse_inc(33);
    ty = cyc + 1;
    pulse_set();
    for (int k = 1; k <= 56; k++) begin
      push($sformatf("run56_tick%0d", k), 12, 34, k, 0, 1'b1, ty + 4 * k);
    end
    step(223);
    pulse_set();
    pulse_set();
    check_now("preload_12_34_56", 12, 34, 56, 2);
    step(1);

    // Asynchronous reset mid-cycle, with set held high across release.
    u_if.set_i = 1'b1;
    #1;
    rst_n = 1'b0;
    check_now("async_reset", 0, 0, 0, 0);
    step(2);
    rst_n = 1'b1;
    tr = cyc;
    step(3);
    check_now("held_button_no_edge", 0, 0, 0, 0);
    push("post_reset_tick", 0, 0, 1, 0, 1'b1, tr + 4);
    u_if.set_i = 1'b0;
    step(3);

    checks++;
    if (sb.size() != 0 || chk_req) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
